// File: rtl/vx_dispatch_arb.sv
// Round-robin arbiter that funnels NUM_REQS dispatch streams into one execute-unit port
// through a 2-entry skid buffer, so out_ready never combinationally reaches in_ready.
module vx_dispatch_arb #(
  parameter  int NUM_REQS      = 4,
  parameter  int DATA_WIDTH    = 512,
  parameter  int PERF_CTR_BITS = 32,
  localparam int SEL_W         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQS-1:0]            in_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQS-1:0]            in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]               out_sel,
  input  logic                           out_ready,
  output logic [PERF_CTR_BITS-1:0]       perf_stalls
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and in_ready is a function of in_valid and registered state only.

  logic [1:0]               count_q, count_d;
  logic                     rd_ptr_q, wr_ptr_q;
  logic [SEL_W-1:0]         last_grant_q, last_grant_d;
  logic [PERF_CTR_BITS-1:0] perf_q, perf_d;
  logic [DATA_WIDTH-1:0]    data_q [2];
  logic [SEL_W-1:0]         sel_q  [2];

  logic             any_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             push;
  logic             pop;
  logic             stall;

  // Search starts just after the last winner and wraps, giving rotating priority.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQS; i++) begin
      if (!any_valid && in_valid[(int'(last_grant_q) + i) % NUM_REQS]) begin
        any_valid = 1'b1;
        grant_idx = SEL_W'((int'(last_grant_q) + i) % NUM_REQS);
      end
    end
  end

  assign push      = any_valid & ~count_q[1] & reset_n;
  assign in_ready  = push ? (NUM_REQS'(1) << grant_idx) : '0;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;
  assign out_data  = data_q[rd_ptr_q];
  assign out_sel   = sel_q[rd_ptr_q];

  always_comb begin
    count_d      = count_q;
    last_grant_d = last_grant_q;
    perf_d       = perf_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push) begin
      last_grant_d = grant_idx;
    end
    if (stall && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      last_grant_q <= SEL_W'(NUM_REQS - 1);
      perf_q       <= '0;
      for (int e = 0; e < 2; e++) begin
        data_q[e] <= '0;
        sel_q[e]  <= '0;
      end
    end else begin
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      perf_q       <= perf_d;
      if (push) begin
        data_q[wr_ptr_q] <= in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_q[wr_ptr_q]  <= grant_idx;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed bench for vx_dispatch_arb: 4 streams, 16-bit records, 4-bit stall counter
// so saturation is reachable in a few cycles.
module tb_vx_dispatch_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PB = 4;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic [PB-1:0]   perf_stalls;

  int checks;
  int errors;

  vx_dispatch_arb #(
    .NUM_REQS(N),
    .DATA_WIDTH(DW),
    .PERF_CTR_BITS(PB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready),
    .perf_stalls(perf_stalls)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  function automatic logic [DW-1:0] rec(input int s, input int t);
    logic [3:0]  hi;
    logic [11:0] lo;
    hi = 4'(s);
    lo = 12'(t);
    return {hi, lo};
  endfunction

  task automatic set_stream(input int s, input int t);
    in_data[s*DW +: DW] = rec(s, t);
  endtask

  // one clock: through the rising edge, back to the falling edge for sampling
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [PB-1:0] zero_p;
    zero_p = '0;
    reset_n   = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int s = 0; s < N; s++) set_stream(s, 'h100 + s);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d exp 0", out_sel); end
    checks++; if (perf_stalls !== zero_p) begin errors++; $display("FAIL reset_perf got %0d exp 0", perf_stalls); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    in_valid = 4'b0000;
    reset_n  = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL idle_in_ready got %b exp 0000", in_ready); end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    int w;
    for (int s = 0; s < N; s++) set_stream(s, 'hA00 + s);
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b exp 0001", in_ready); end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      w = (k - 1) % 4;
      exp_r = 4'b0001 << (k % 4);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid k=%0d got %b exp 1", k, out_valid); end
      checks++; if (out_sel !== 2'(w)) begin errors++; $display("FAIL rr_sel k=%0d got %0d exp %0d", k, out_sel, w); end
      checks++; if (out_data !== rec(w, 'hA00 + w)) begin errors++; $display("FAIL rr_data k=%0d got %h exp %h", k, out_data, rec(w, 'hA00 + w)); end
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL rr_ready k=%0d got %b exp %b", k, in_ready, exp_r); end
    end
    in_valid = 4'b0000;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_stream(0, 'hD01);
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready0 got %b exp 0001", in_ready); end
    cyc();
    set_stream(0, 'hD02);
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready1 got %b exp 0001", in_ready); end
    checks++; if (perf_stalls !== 4'd0) begin errors++; $display("FAIL bp_perf0 got %0d exp 0", perf_stalls); end
    cyc();
    set_stream(0, 'hD03);
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready got %b exp 0000", in_ready); end
    checks++; if (out_data !== rec(0, 'hD01)) begin errors++; $display("FAIL bp_head got %h exp %h", out_data, rec(0, 'hD01)); end
    checks++; if (perf_stalls !== 4'd1) begin errors++; $display("FAIL bp_perf1 got %0d exp 1", perf_stalls); end
    cyc();
    checks++; if (perf_stalls !== 4'd2) begin errors++; $display("FAIL bp_perf2 got %0d exp 2", perf_stalls); end
    checks++; if (out_data !== rec(0, 'hD01)) begin errors++; $display("FAIL bp_hold got %h exp %h", out_data, rec(0, 'hD01)); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL bp_hold_sel got %0d exp 0", out_sel); end
    cyc();
    checks++; if (perf_stalls !== 4'd3) begin errors++; $display("FAIL bp_perf3 got %0d exp 3", perf_stalls); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_ready_path got %b exp 0000", in_ready); end
    cyc();
    checks++; if (out_data !== rec(0, 'hD02)) begin errors++; $display("FAIL bp_drain1 got %h exp %h", out_data, rec(0, 'hD02)); end
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume got %b exp 0001", in_ready); end
    checks++; if (perf_stalls !== 4'd3) begin errors++; $display("FAIL bp_perf_hold got %0d exp 3", perf_stalls); end
    cyc();
    checks++; if (out_data !== rec(0, 'hD03)) begin errors++; $display("FAIL bp_drain2 got %h exp %h", out_data, rec(0, 'hD03)); end
    in_valid = 4'b0000;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    set_stream(1, 'hA0A);
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready got %b exp 0010", in_ready); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      exp_d = rec(1, 'hA0A + k);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got %b exp 1", k, out_valid); end
      checks++; if (out_data !== exp_d) begin errors++; $display("FAIL b2b_data k=%0d got %h exp %h", k, out_data, exp_d); end
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL b2b_count1 k=%0d got %b exp 0010", k, in_ready); end
      set_stream(1, 'hA0A + k + 1);
      if (k == 2) in_valid = 4'b0000;
    end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_skip_ahead();
    for (int s = 0; s < N; s++) set_stream(s, 'h5A0 + s);
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL skip_wrap got %b exp 0001", in_ready); end
    cyc();
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL skip_sel0 got %0d exp 0", out_sel); end
    in_valid = 4'b1001;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL skip_to3 got %b exp 1000", in_ready); end
    cyc();
    checks++; if (out_sel !== 2'd3) begin errors++; $display("FAIL skip_sel3 got %0d exp 3", out_sel); end
    checks++; if (out_data !== rec(3, 'h5A3)) begin errors++; $display("FAIL skip_data3 got %h exp %h", out_data, rec(3, 'h5A3)); end
    in_valid = 4'b0000;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skip_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    set_stream(2, 'h222);
    cyc();
    cyc();
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rm_full got %b exp 0000", in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rm_async_data got %h exp 0000", out_data); end
    checks++; if (perf_stalls !== 4'd0) begin errors++; $display("FAIL rm_async_perf got %0d exp 0", perf_stalls); end
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1001;
    set_stream(0, 'h0F0);
    set_stream(3, 'h3F3);
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant got %b exp 0001", in_ready); end
    cyc();
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL rm_sel got %0d exp 0", out_sel); end
    checks++; if (out_data !== rec(0, 'h0F0)) begin errors++; $display("FAIL rm_data got %h exp %h", out_data, rec(0, 'h0F0)); end
    in_valid = 4'b0000;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    checks++; if (perf_stalls !== 4'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", perf_stalls); end
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    set_stream(0, 'h5A7);
    cyc();
    in_valid = 4'b0000;
    checks++; if (perf_stalls !== 4'd0) begin errors++; $display("FAIL sat_first got %0d exp 0", perf_stalls); end
    for (int k = 0; k < 14; k++) cyc();
    checks++; if (perf_stalls !== 4'd14) begin errors++; $display("FAIL sat_max_m1 got %0d exp 14", perf_stalls); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (perf_stalls !== 4'd15) begin errors++; $display("FAIL sat_hold k=%0d got %0d exp 15", k, perf_stalls); end
    end
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain got %b exp 0", out_valid); end
    checks++; if (perf_stalls !== 4'd15) begin errors++; $display("FAIL sat_final got %0d exp 15", perf_stalls); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_skip_ahead();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
